// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: depth derivation and Gray/binary conversion.
// Used by both the write-side and read-side pointer blocks.
package fifo_pkg;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g,
    input int unsigned w
  );
    logic [31:0] b;
    b = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < 31) b[i] = b[i+1] ^ g[i];
      else        b[i] = g[i];
      if (i >= int'(w)) b[i] = 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write-side and read-side pointer blocks.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, Gray publish and full/overflow flags for the async FIFO.
// Optional registered almost_full is built only with FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rgray_sync,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wgray,
  output logic                  full,
  output logic                  overflow,
  output logic                  almost_full
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rgray_full;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          af_d;
  logic          accept;

  assign accept = winc & ~full_q;
  assign wbin_d = wbin_q + PW'(accept);
  assign wgray_d = PW'(bin2gray(32'(wbin_d)));

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign rgray_full = {~rgray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                       rgray_sync[ADDR_WIDTH-2:0]};
  assign full_d = (wgray_d == rgray_full);
  assign ovf_d  = winc & full_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] level;
  logic          af_q;

  fifo_gray2bin #(.W(PW)) u_g2b (
    .gray_i (rgray_sync),
    .bin_o  (rbin)
  );

  assign level = wbin_d - rbin;
  assign af_d  = full_d | (level >= PW'(DEPTH - AF_MARGIN));

  always_ff @(posedge clk) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= af_d;
  end

  assign almost_full = af_q;
`else
  assign af_d        = 1'b0;
  assign almost_full = af_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wen      = accept;
  assign waddr    = wbin_q[ADDR_WIDTH-1:0];
  assign wgray    = wgray_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed scenarios plus random traffic,
// checked against an occupancy-based model of the write side.
module tb_fifo_wptr_full;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic          clk;
  logic          rst;
  logic          winc;
  logic [AW:0]   rgray_sync;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wgray;
  logic          full;
  logic          overflow;
  logic          almost_full;

  int n_chk;
  int n_fail;

  // Model: pointers as plain counters modulo 2*DEPTH.
  int m_wptr;
  int m_rptr;
  bit m_full;
  bit m_ovf;
  bit m_af;

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clk         (clk),
    .rst         (rst),
    .winc        (winc),
    .rgray_sync  (rgray_sync),
    .wen         (wen),
    .waddr       (waddr),
    .wgray       (wgray),
    .full        (full),
    .overflow    (overflow),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input int p);
    int q;
    q = p % (2 * DEPTH);
    return (AW+1)'(q ^ (q >> 1));
  endfunction

  function automatic bit af_en();
`ifdef FIFO_ALMOST_FULL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle.
  task automatic tick(input bit w, input int r, input bit rs);
    int occ;
    winc       = w;
    rst        = rs;
    m_rptr     = r % (2 * DEPTH);
    rgray_sync = to_gray(m_rptr);
    @(posedge clk);
    if (rs) begin
      m_wptr = 0; m_full = 0; m_ovf = 0; m_af = 0;
    end else begin
      m_ovf = w && m_full;
      if (w && !m_full) m_wptr = (m_wptr + 1) % (2 * DEPTH);
      occ    = (m_wptr - m_rptr + 2 * DEPTH) % (2 * DEPTH);
      m_full = (occ == DEPTH);
      m_af   = af_en() && (occ >= DEPTH - AFM);
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 1);
    tick(1, 0, 1);
    n_chk++;
    if ({wgray, waddr, full, overflow, almost_full} !== '0) begin
      n_fail++;
      $display("FAIL reset: wgray=%b waddr=%0d full=%b ovf=%b af=%b want all 0",
               wgray, waddr, full, overflow, almost_full);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 0, 0);
      n_chk++;
      if (wgray !== to_gray(m_wptr) || full !== m_full) begin
        n_fail++;
        $display("FAIL fill[%0d]: wgray=%b full=%b want %b %b",
                 i, wgray, full, to_gray(m_wptr), m_full);
      end
    end
    winc = 1'b1;
    #1;
    n_chk++;
    if (full !== 1'b1 || wgray !== 4'b1100 || waddr !== 3'd0 || wen !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_end: full=%b wgray=%b waddr=%0d wen=%b want 1 1100 0 0",
               full, wgray, waddr, wen);
    end
  endtask

  task automatic test_overflow();
    tick(1, 0, 0);
    n_chk++;
    if (overflow !== 1'b1 || wgray !== 4'b1100 || waddr !== 3'd0) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b wgray=%b waddr=%0d want 1 1100 0",
               overflow, wgray, waddr);
    end
    tick(0, 0, 0);
    n_chk++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse: ovf=%b full=%b want 0 1", overflow, full);
    end
  endtask

  task automatic test_drain_refill();
    tick(0, 1, 0);
    n_chk++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: full=%b want 0", full);
    end
    tick(1, 1, 0);
    n_chk++;
    if (wgray !== 4'b1101 || full !== 1'b1 || full !== m_full) begin
      n_fail++;
      $display("FAIL refill: wgray=%b full=%b want 1101 1", wgray, full);
    end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    int          steps;
    int          wraps;
    int          last;
    steps = 0;
    wraps = 0;
    // Read side catches up immediately so the FIFO never fills.
    tick(0, m_wptr, 0);
    for (int i = 0; i < 20; i++) begin
      prev = wgray;
      last = m_wptr;
      tick(1, m_wptr, 0);
      if (m_wptr < last) wraps++;
      n_chk++;
      if (full !== 1'b0 || wgray !== to_gray(m_wptr) ||
          $countones(prev ^ wgray) != 1) begin
        n_fail++;
        $display("FAIL wrap[%0d]: full=%b wgray=%b prev=%b want 0 %b one-bit step",
                 i, full, wgray, prev, to_gray(m_wptr));
      end
      steps++;
    end
    n_chk++;
    if (wraps != 1 || steps != 20) begin
      n_fail++;
      $display("FAIL wrap_count: wraps=%0d want 1", wraps);
    end
  endtask

  task automatic test_random();
    int r;
    int occ;
    for (int i = 0; i < 300; i++) begin
      r   = m_rptr;
      occ = (m_wptr - m_rptr + 2 * DEPTH) % (2 * DEPTH);
      if (occ > 0 && $urandom_range(0, 2) == 0) r = r + 1;
      winc       = 1'($urandom_range(0, 3) != 0);
      rgray_sync = to_gray(r);
      #1;
      n_chk++;
      if (wen !== (winc && !m_full)) begin
        n_fail++;
        $display("FAIL rand_wen[%0d]: wen=%b want %b", i, wen, winc && !m_full);
      end
      tick(winc, r, 0);
      n_chk++;
      if (wgray !== to_gray(m_wptr) || waddr !== AW'(m_wptr % DEPTH) ||
          full !== m_full || overflow !== m_ovf || almost_full !== m_af) begin
        n_fail++;
        $display("FAIL rand[%0d]: g=%b a=%0d f=%b o=%b af=%b want %b %0d %b %b %b",
                 i, wgray, waddr, full, overflow, almost_full, to_gray(m_wptr),
                 m_wptr % DEPTH, m_full, m_ovf, m_af);
      end
    end
  endtask

  task automatic test_midreset_af();
    tick(0, 0, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    n_chk++;
    if (waddr !== 3'd5) begin
      n_fail++;
      $display("FAIL pre_reset: waddr=%0d want 5", waddr);
    end
    tick(1, 0, 1);
    n_chk++;
    if ({wgray, waddr, full, overflow, almost_full} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: wgray=%b waddr=%0d full=%b ovf=%b af=%b want all 0",
               wgray, waddr, full, overflow, almost_full);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0);
      n_chk++;
      if (almost_full !== m_af) begin
        n_fail++;
        $display("FAIL af[%0d]: af=%b want %b", i, almost_full, m_af);
      end
    end
    n_chk++;
    if (almost_full !== af_en()) begin
      n_fail++;
      $display("FAIL af_final: af=%b want %b", almost_full, af_en());
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    m_wptr     = 0;
    m_rptr     = 0;
    m_full     = 0;
    m_ovf      = 0;
    m_af       = 0;
    rst        = 1'b1;
    winc       = 1'b0;
    rgray_sync = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_drain_refill();
    test_wrap();
    test_random();
    test_midreset_af();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
